// File: rtl/shift_pkg.sv
// Shared shift-type encodings, funct3 codes and the stage-A payload for the shift execute stage.
package shift_pkg;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10,
    SH_ILL = 2'b11
  } shift_type_e;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

  typedef struct packed {
    logic [31:0] rs1;
    logic [4:0]  shamt;
    shift_type_e sh_type;
    logic [4:0]  rd;
    logic        illegal;
  } stage_a_t;

endpackage

// File: rtl/shift_exec_stage_barrel_shifter.sv
// Combinational barrel shifter: logical left/right and arithmetic right; illegal type yields zero.
module BarrelShifter
  import shift_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] data_in,
  input  logic [4:0]      shamt,
  input  shift_type_e     shift_type,
  output logic [XLEN-1:0] data_out
);

  always_comb begin
    data_out = '0;
    case (shift_type)
      SH_SLL:  data_out = data_in << shamt;
      SH_SRL:  data_out = data_in >> shamt;
      SH_SRA:  data_out = $unsigned($signed(data_in) >>> shamt);
      default: data_out = '0;
    endcase
  end

endmodule

// File: rtl/shift_exec_stage.sv
// Two-stage shift execute stage: decode/operand register (A), barrel shifter, result register (B)
// with valid/ready backpressure, flush, illegal-encoding detection and a saturating retire counter.
module shift_exec_stage
  import shift_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       funct3,
  input  logic             funct7_b5,
  input  logic             is_imm,
  input  logic [XLEN-1:0]  rs1_val,
  input  logic [XLEN-1:0]  rs2_val,
  input  logic [11:0]      imm,
  input  logic [4:0]       rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [4:0]       out_rd,
  output logic             out_illegal,
  output logic [CNT_W-1:0] op_count
);

  stage_a_t        dec;
  stage_a_t        a_pl;
  logic            a_valid;
  logic            b_valid;
  logic            a_adv;
  logic            b_adv;
  logic            in_xfer;
  logic            out_xfer;
  logic            b5;
  logic [XLEN-1:0] sh_out;

  // Register-form shift amount uses only rs2_val[4:0].
  logic unused_rs2_hi;
  assign unused_rs2_hi = ^rs2_val[XLEN-1:5];

  always_comb begin
    b5          = is_imm ? imm[10] : funct7_b5;
    dec.rs1     = rs1_val;
    dec.shamt   = is_imm ? imm[4:0] : rs2_val[4:0];
    dec.rd      = rd;
    dec.illegal = 1'b0;
    dec.sh_type = SH_ILL;
    case (funct3)
      F3_SLL: begin
        if (b5) dec.illegal = 1'b1;
        else    dec.sh_type = SH_SLL;
      end
      F3_SR:   dec.sh_type = b5 ? SH_SRA : SH_SRL;
      default: dec.illegal = 1'b1;
    endcase
    if (is_imm && (imm[11] || (imm[9:5] != '0))) dec.illegal = 1'b1;
    if (dec.illegal) dec.sh_type = SH_ILL;
  end

  assign b_adv     = !b_valid || out_ready;
  assign a_adv     = a_valid && b_adv;
  assign in_ready  = !a_valid || b_adv;
  assign in_xfer   = in_valid && in_ready;
  assign out_valid = b_valid;
  assign out_xfer  = b_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid <= 1'b0;
      a_pl    <= '0;
    end else if (flush) begin
      a_valid <= 1'b0;
    end else if (in_xfer) begin
      a_valid <= 1'b1;
      a_pl    <= dec;
    end else if (a_adv) begin
      a_valid <= 1'b0;
    end
  end

  BarrelShifter #(.XLEN(XLEN)) u_shifter (
    .data_in    (a_pl.rs1),
    .shamt      (a_pl.shamt),
    .shift_type (a_pl.sh_type),
    .data_out   (sh_out)
  );

  // Flush wins over a same-cycle output transfer, so the counter must not see it either.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_valid     <= 1'b0;
      out_result  <= '0;
      out_rd      <= '0;
      out_illegal <= 1'b0;
      op_count    <= '0;
    end else begin
      if (flush) begin
        b_valid <= 1'b0;
      end else if (a_adv) begin
        b_valid     <= 1'b1;
        out_result  <= a_pl.illegal ? '0 : sh_out;
        out_rd      <= a_pl.rd;
        out_illegal <= a_pl.illegal;
      end else if (out_xfer) begin
        b_valid <= 1'b0;
      end
      if (!flush && out_xfer && !out_illegal && (op_count != '1))
        op_count <= op_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_shift_exec_stage.sv
// Directed self-checking bench for shift_exec_stage: vector table plus stall, flush,
// counter saturation and asynchronous reset sequences.
module tb_shift_exec_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  funct3;
  logic        funct7_b5;
  logic        is_imm;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [11:0] imm;
  logic [4:0]  rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_illegal;
  logic [15:0] op_count;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  shift_exec_stage #(.XLEN(32), .CNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .funct3      (funct3),
    .funct7_b5   (funct7_b5),
    .is_imm      (is_imm),
    .rs1_val     (rs1_val),
    .rs2_val     (rs2_val),
    .imm         (imm),
    .rd          (rd),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_rd      (out_rd),
    .out_illegal (out_illegal),
    .op_count    (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [2:0]  f3;
    logic        b5;
    logic        imm_form;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [11:0] immv;
    logic [4:0]  rdv;
    logic [31:0] exp_res;
    logic        exp_ill;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_op(input logic [2:0] f3, input logic b5, input logic imm_form,
                          input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [11:0] immv, input logic [4:0] rdv);
    funct3    = f3;
    funct7_b5 = b5;
    is_imm    = imm_form;
    rs1_val   = rs1;
    rs2_val   = rs2;
    imm       = immv;
    rd        = rdv;
  endtask

  initial begin
    vecs[0]  = '{3'b001, 1'b0, 1'b0, 32'h0000_0001, 32'h0000_0024, 12'h000, 5'd1,  32'h0000_0010, 1'b0};
    vecs[1]  = '{3'b101, 1'b0, 1'b1, 32'h8000_0000, 32'h0000_0000, 12'h41F, 5'd2,  32'hFFFF_FFFF, 1'b0};
    vecs[2]  = '{3'b101, 1'b1, 1'b1, 32'h8000_0000, 32'h0000_0000, 12'h01F, 5'd3,  32'h0000_0001, 1'b0};
    vecs[3]  = '{3'b001, 1'b1, 1'b0, 32'h0000_FFFF, 32'h0000_0001, 12'h000, 5'd4,  32'h0000_0000, 1'b1};
    vecs[4]  = '{3'b001, 1'b0, 1'b1, 32'h0000_0001, 32'h0000_0000, 12'h220, 5'd5,  32'h0000_0000, 1'b1};
    vecs[5]  = '{3'b101, 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFE0, 12'h000, 5'd6,  32'h8000_0000, 1'b0};
    vecs[6]  = '{3'b101, 1'b1, 1'b0, 32'hF000_0000, 32'h0000_0004, 12'h000, 5'd7,  32'hFF00_0000, 1'b0};
    vecs[7]  = '{3'b101, 1'b0, 1'b0, 32'hF000_0000, 32'h0000_0004, 12'h000, 5'd8,  32'h0F00_0000, 1'b0};
    vecs[8]  = '{3'b000, 1'b0, 1'b0, 32'h0000_0005, 32'h0000_0001, 12'h000, 5'd9,  32'h0000_0000, 1'b1};
    vecs[9]  = '{3'b101, 1'b0, 1'b1, 32'h8000_0000, 32'h0000_0000, 12'hC01, 5'd10, 32'h0000_0000, 1'b1};
    vecs[10] = '{3'b001, 1'b0, 1'b1, 32'h0000_0003, 32'h0000_0000, 12'h005, 5'd11, 32'h0000_0060, 1'b0};
    vecs[11] = '{3'b001, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_0100, 12'h000, 5'd12, 32'hDEAD_BEEF, 1'b0};
    vecs[12] = '{3'b101, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_001F, 12'h000, 5'd13, 32'h0000_0001, 1'b0};

    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drive_op(3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 12'h0, 5'd0);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", {31'b0, out_valid}, 32'h0);
    check("rst_out_result", out_result, 32'h0);
    check("rst_out_rd", {27'b0, out_rd}, 32'h0);
    check("rst_out_illegal", {31'b0, out_illegal}, 32'h0);
    check("rst_op_count", {16'b0, op_count}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'h1);

    // Single ops through an empty pipe: latency 2, result, rd, illegal, counter
    for (int i = 0; i < NV; i++) begin
      drive_op(vecs[i].f3, vecs[i].b5, vecs[i].imm_form, vecs[i].rs1, vecs[i].rs2,
               vecs[i].immv, vecs[i].rdv);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1;
      check($sformatf("v%0d_in_ready", i), {31'b0, in_ready}, 32'h1);
      @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("v%0d_lat_early", i), {31'b0, out_valid}, 32'h0);
      @(negedge clk);
      check($sformatf("v%0d_out_valid", i), {31'b0, out_valid}, 32'h1);
      check($sformatf("v%0d_result", i), out_result, vecs[i].exp_res);
      check($sformatf("v%0d_rd", i), {27'b0, out_rd}, {27'b0, vecs[i].rdv});
      check($sformatf("v%0d_illegal", i), {31'b0, out_illegal}, {31'b0, vecs[i].exp_ill});
      if (!vecs[i].exp_ill) exp_cnt++;
      @(negedge clk);
      check($sformatf("v%0d_op_count", i), {16'b0, op_count}, exp_cnt);
      check($sformatf("v%0d_drained", i), {31'b0, out_valid}, 32'h0);
    end

    // Back-to-back ops with a 3-cycle downstream stall
    begin
      int issue = 0;
      int coll = 0;
      bit drop_seen = 0;
      logic [31:0] exp_res [4];
      logic [4:0]  exp_rd [4];
      for (int i = 0; i < 4; i++) begin
        exp_res[i] = (i + 1) << 1;
        exp_rd[i]  = 5'(20 + i);
      end
      for (int cyc = 0; cyc < 30 && coll < 4; cyc++) begin
        @(negedge clk);
        out_ready = (cyc >= 5);
        in_valid  = (issue < 4);
        if (issue < 4)
          drive_op(3'b001, 1'b0, 1'b0, 32'(issue + 1), 32'h1, 12'h0, 5'(20 + issue));
        #1;
        if (!drop_seen && in_valid && !in_ready) begin
          drop_seen = 1;
          check("stall_accepts_before_drop", issue, 2);
        end
        if (cyc == 3 || cyc == 4)
          check($sformatf("stall_in_ready_c%0d", cyc), {31'b0, in_ready}, 32'h0);
        if (out_valid && !out_ready) begin
          check($sformatf("stall_hold_result_c%0d", cyc), out_result, exp_res[coll]);
          check($sformatf("stall_hold_rd_c%0d", cyc), {27'b0, out_rd}, {27'b0, exp_rd[coll]});
        end
        if (in_valid && in_ready) issue++;
        if (out_valid && out_ready) begin
          check($sformatf("drain%0d_result", coll), out_result, exp_res[coll]);
          check($sformatf("drain%0d_rd", coll), {27'b0, out_rd}, {27'b0, exp_rd[coll]});
          coll++;
          exp_cnt++;
        end
      end
      check("stall_drop_seen", {31'b0, drop_seen}, 32'h1);
      check("stall_all_drained", coll, 4);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check("stall_no_duplicate", {31'b0, out_valid}, 32'h0);
      check("stall_op_count", {16'b0, op_count}, exp_cnt);
    end

    // Flush with both stages occupied and a same-cycle input and output transfer
    out_ready = 1'b0;
    drive_op(3'b001, 1'b0, 1'b0, 32'h1, 32'h2, 12'h0, 5'd25);
    in_valid = 1'b1;
    @(negedge clk);
    drive_op(3'b001, 1'b0, 1'b0, 32'h1, 32'h3, 12'h0, 5'd26);
    @(negedge clk);
    drive_op(3'b001, 1'b0, 1'b0, 32'h1, 32'h4, 12'h0, 5'd27);
    check("flush_pre_valid", {31'b0, out_valid}, 32'h1);
    flush     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("flush_out_valid", {31'b0, out_valid}, 32'h0);
    check("flush_in_ready", {31'b0, in_ready}, 32'h1);
    @(negedge clk);
    check("flush_dropped_input", {31'b0, out_valid}, 32'h0);
    @(negedge clk);
    check("flush_op_count", {16'b0, op_count}, exp_cnt);

    // Counter saturation: 2^16 + 3 legal ops at full throughput
    begin
      int n_ops = 65536 + 3;
      int issued = 0;
      int sat_exp;
      out_ready = 1'b1;
      drive_op(3'b101, 1'b0, 1'b0, 32'h8000_0000, 32'h1, 12'h0, 5'd30);
      for (int cyc = 0; cyc < n_ops + 20 && issued < n_ops; cyc++) begin
        @(negedge clk);
        in_valid = (issued < n_ops);
        #1;
        if (in_valid && in_ready) issued++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      sat_exp = (exp_cnt + n_ops > 65535) ? 65535 : exp_cnt + n_ops;
      check("sat_issued", issued, n_ops);
      check("sat_op_count", {16'b0, op_count}, sat_exp);
    end

    // Asynchronous reset mid-stream
    drive_op(3'b001, 1'b0, 1'b0, 32'h1, 32'h4, 12'h0, 5'd7);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("arst_pre_valid", {31'b0, out_valid}, 32'h1);
    check("arst_pre_result", out_result, 32'h10);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'b0, out_valid}, 32'h0);
    check("arst_out_result", out_result, 32'h0);
    check("arst_out_rd", {27'b0, out_rd}, 32'h0);
    check("arst_out_illegal", {31'b0, out_illegal}, 32'h0);
    check("arst_op_count", {16'b0, op_count}, 32'h0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_in_ready", {31'b0, in_ready}, 32'h1);
    check("arst_empty", {31'b0, out_valid}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
